watch_ctrl: RTL

WATCH_CTRL -- requirements
Module: watch_ctrl

---
 rtl/watch_pkg.sv | 17 +
 rtl/watch_ctrl_bcd_mod60_counter.sv | 48 ++++
 rtl/watch_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared mode encodings and BCD digit width for the watch controller
package watch_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_MIN = 2'b01,
    MODE_SET_SEC = 2'b10,
    MODE_BAD     = 2'b11
  } mode_e;

  localparam logic [3:0] BLANK_NONE = 4'b0000;
  localparam logic [3:0] BLANK_MIN  = 4'b1100;
  localparam logic [3:0] BLANK_SEC  = 4'b0011;

endpackage

// File: rtl/watch_ctrl_bcd_mod60_counter.sv
// rtl/watch_ctrl_bcd_mod60_counter.sv - two-digit BCD counter 00..59 with clear and wrap flag
module bcd_mod60_counter
  import watch_pkg::*;
(
  input  logic             clk,
  input  logic             reset_p,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] dec1,
  output logic [BCD_W-1:0] dec10,
  output logic             wrap
);

  logic [BCD_W-1:0] dec1_q, dec1_d;
  logic [BCD_W-1:0] dec10_q, dec10_d;

  // wrap is combinational so the next counter can step on the same edge
  assign wrap  = inc & ~clr & (dec10_q >= 4'd5) & (dec1_q >= 4'd9);
  assign dec1  = dec1_q;
  assign dec10 = dec10_q;

  always_comb begin
    dec1_d  = dec1_q;
    dec10_d = dec10_q;
    if (clr) begin
      dec1_d  = '0;
      dec10_d = '0;
    end else if (inc) begin
      if (dec1_q >= 4'd9) begin
        dec1_d  = '0;
        dec10_d = (dec10_q >= 4'd5) ? '0 : dec10_q + 4'd1;
      end else begin
        dec1_d = dec1_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      dec1_q  <= '0;
      dec10_q <= '0;
    end else begin
      dec1_q  <= dec1_d;
      dec10_q <= dec10_d;
    end
  end

endmodule

// File: rtl/watch_ctrl.sv
// rtl/watch_ctrl.sv - mm:ss watch with run/set modes, button editing and set-mode digit blinking
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int BLINK_MS = 500
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             tick_sec,
  input  logic             tick_msec,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             btn_clr,
  output logic [BCD_W-1:0] sec1,
  output logic [BCD_W-1:0] sec10,
  output logic [BCD_W-1:0] min1,
  output logic [BCD_W-1:0] min10,
  output logic [1:0]       mode,
  output logic [3:0]       blank,
  output logic             min_carry
);

  localparam int CW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  mode_e         state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    blank_q, blank_d;
  logic          min_carry_q, min_carry_d;

  logic mode_ev, clr_ev, inc_ev, tick_ev;
  logic is_run, is_smin, is_ssec;
  logic sec_inc, sec_clr, sec_wrap;
  logic min_inc, min_clr, min_wrap;

  // one event per cycle: mode > clr > inc > tick_sec
  assign mode_ev = btn_mode;
  assign clr_ev  = btn_clr & ~btn_mode;
  assign inc_ev  = btn_inc & ~btn_mode & ~btn_clr;
  assign tick_ev = tick_sec & ~btn_mode & ~btn_clr & ~btn_inc;

  assign is_run  = (state_q == MODE_RUN);
  assign is_smin = (state_q == MODE_SET_MIN);
  assign is_ssec = (state_q == MODE_SET_SEC);

  assign sec_inc = (is_ssec & inc_ev) | (is_run & tick_ev);
  assign sec_clr = clr_ev & (is_run | is_ssec);
  assign min_inc = (is_smin & inc_ev) | (is_run & tick_ev & sec_wrap);
  assign min_clr = clr_ev & (is_run | is_smin);

  bcd_mod60_counter u_sec (
    .clk    (clk),
    .reset_p(reset_p),
    .inc    (sec_inc),
    .clr    (sec_clr),
    .dec1   (sec1),
    .dec10  (sec10),
    .wrap   (sec_wrap)
  );

  bcd_mod60_counter u_min (
    .clk    (clk),
    .reset_p(reset_p),
    .inc    (min_inc),
    .clr    (min_clr),
    .dec1   (min1),
    .dec10  (min10),
    .wrap   (min_wrap)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    phase_d     = 1'b0;
    blank_d     = BLANK_NONE;
    min_carry_d = is_run & tick_ev & sec_wrap & min_wrap;

    case (state_q)
      MODE_RUN:     if (mode_ev) state_d = MODE_SET_MIN;
      MODE_SET_MIN: if (mode_ev) state_d = MODE_SET_SEC;
      MODE_SET_SEC: if (mode_ev) state_d = MODE_RUN;
      default:      state_d = MODE_RUN;
    endcase

    // any edit restarts the blink from the visible phase
    if ((is_smin | is_ssec) & ~(mode_ev | clr_ev | inc_ev)) begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (tick_msec) begin
        if (cnt_q == CW'(BLINK_MS - 1)) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    if (phase_d) begin
      if (state_d == MODE_SET_MIN)      blank_d = BLANK_MIN;
      else if (state_d == MODE_SET_SEC) blank_d = BLANK_SEC;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q     <= MODE_RUN;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      blank_q     <= BLANK_NONE;
      min_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      blank_q     <= blank_d;
      min_carry_q <= min_carry_d;
    end
  end

  assign mode      = state_q;
  assign blank     = blank_q;
  assign min_carry = min_carry_q;

endmodule
